// File: rtl/y_signature_compactor.sv
// rtl/y_signature_compactor.sv - MISR signature compactor for a fuzz DUT result bus
//
// Absorbs DATA_W-bit y_in into an SIG_W-bit MISR over a run of num_samples
// cycles, then offers the signature on a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock (same clock as the DUT)
//   rst_n        asynchronous active-low reset
//   start        begin a run; honoured only in IDLE
//   num_samples  run length N; sampled when start is accepted
//   y_in         DUT result bus
//   busy         high in RUN or DONE
//   sample_cnt   samples absorbed in the current run
//   sig_out      signature; stable while sig_valid=1
//   sig_valid    signature ready (DONE only)
//   sig_ready    consumer accepts signature

module y_signature_compactor #(
    parameter int          DATA_W = 87,
    parameter int          SIG_W  = 32,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter logic [31:0] SEED   = 32'hFFFFFFFF,
    parameter int          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic [DATA_W-1:0] y_in,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [SIG_W-1:0]  sig_out,
    output logic              sig_valid,
    input  logic              sig_ready
);

    localparam int TOP_W = DATA_W - 2 * SIG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [SIG_W-1:0]   sig, sig_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [CNT_W-1:0]   n_lat, n_lat_next;

    logic [SIG_W-1:0]   top_chunk;
    logic [SIG_W-1:0]   fold;
    logic [SIG_W-1:0]   misr_step;
    logic [CNT_W-1:0]   cnt_inc;

    // The upper chunk of y is narrower than the signature; zero-extend it.
    assign top_chunk = {{(SIG_W - TOP_W){1'b0}}, y_in[DATA_W-1:2*SIG_W]};
    assign fold      = y_in[SIG_W-1:0] ^ y_in[2*SIG_W-1:SIG_W] ^ top_chunk;
    assign misr_step = {sig[SIG_W-2:0], 1'b0}
                     ^ (sig[SIG_W-1] ? POLY[SIG_W-1:0] : {SIG_W{1'b0}})
                     ^ fold;
    assign cnt_inc   = cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sig   <= SEED[SIG_W-1:0];
            cnt   <= '0;
            n_lat <= '0;
        end else begin
            state <= state_next;
            sig   <= sig_next;
            cnt   <= cnt_next;
            n_lat <= n_lat_next;
        end
    end

    always_comb begin
        state_next = state;
        sig_next   = sig;
        cnt_next   = cnt;
        n_lat_next = n_lat;
        case (state)
            IDLE: begin
                if (start) begin
                    sig_next = SEED[SIG_W-1:0];
                    cnt_next = '0;
                    if (num_samples != '0) begin
                        n_lat_next = num_samples;
                        state_next = RUN;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                sig_next = misr_step;
                cnt_next = cnt_inc;
                // Leave on the edge that absorbs the Nth sample.
                if (cnt_inc == n_lat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (sig_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode flops only; no input reaches an output combinationally.
    assign busy       = (state != IDLE);
    assign sig_valid  = (state == DONE);
    assign sig_out    = sig;
    assign sample_cnt = cnt;

endmodule

// File: tb/tb_y_signature_compactor.sv
// tb/tb_y_signature_compactor.sv - scoreboard testbench for y_signature_compactor

module tb_y_signature_compactor;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] num_samples;
    logic [86:0] y_in;
    logic        busy;
    logic [15:0] sample_cnt;
    logic [31:0] sig_out;
    logic        sig_valid;
    logic        sig_ready;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_q [$];

    y_signature_compactor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_samples (num_samples),
        .y_in        (y_in),
        .busy        (busy),
        .sample_cnt  (sample_cnt),
        .sig_out     (sig_out),
        .sig_valid   (sig_valid),
        .sig_ready   (sig_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signature update as polynomial arithmetic: multiply by x modulo the
    // 33-bit polynomial x^32 + POLY, then add the folded sample.
    function automatic logic [31:0] model_step(input logic [31:0] s, input logic [86:0] y);
        logic [32:0] t;
        logic [31:0] f;
        logic [22:0] hi;
        hi = y[86:64];
        f  = y[31:0] ^ y[63:32] ^ {9'd0, hi};
        t  = {s, 1'b0};
        if (t[32]) t = t ^ {1'b1, POLY};
        return t[31:0] ^ f;
    endfunction

    function automatic logic [86:0] rand_y();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[86:0];
    endfunction

    // Monitor: every accepted signature must match the next scoreboard entry.
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && sig_valid && sig_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sig: got %h/%0d with empty scoreboard", sig_out, sample_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if ({sig_out, sample_cnt} !== e) begin
                        errors++;
                        $display("FAIL scoreboard_sig: got sig %h cnt %0d expected sig %h cnt %0d",
                                 sig_out, sample_cnt, e[47:16], e[15:0]);
                    end
                end
            end
        end
    end

    task automatic do_run(input int n, input bit use_fixed, input logic [86:0] fy,
                          input bit toggle_n, input bit ready_early);
        logic [86:0] ys [$];
        logic [31:0] s;
        logic [15:0] n16;
        int w;
        n16 = n[15:0];
        ys.delete();
        s = SEED;
        for (int i = 0; i < n; i++) ys.push_back(use_fixed ? fy : rand_y());
        for (int i = 0; i < n; i++) s = model_step(s, ys[i]);
        exp_q.push_back({s, n16});

        num_samples = n16;
        start       = 1'b1;
        sig_ready   = ready_early;
        y_in        = rand_y();
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("run_busy", {63'd0, busy}, 64'd1);
            y_in = ys[i];
            if (toggle_n) num_samples = $urandom_range(1, 65535);
            tick();
            check("run_cnt", {48'd0, sample_cnt}, 64'(i + 1));
        end
        check("valid_latency", {63'd0, sig_valid}, 64'd1);
        w = 0;
        while (!sig_valid && w < 5) begin
            tick();
            w++;
        end
        sig_ready = 1'b1;
        tick();
        sig_ready = 1'b0;
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_valid", {63'd0, sig_valid}, 64'd0);
        check("idle_sig_hold", {32'd0, sig_out}, {32'd0, s});
    endtask

    initial begin
        logic [31:0] s;
        logic [86:0] ys5 [4];

        rst_n       = 1'b0;
        start       = 1'b0;
        num_samples = '0;
        y_in        = '0;
        sig_ready   = 1'b0;
        #23;
        check("reset_sig", {32'd0, sig_out}, {32'd0, SEED});
        check("reset_cnt", {48'd0, sample_cnt}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_valid", {63'd0, sig_valid}, 64'd0);
        rst_n = 1'b1;
        tick();

        // T2: single zero sample.
        do_run(1, 1'b1, 87'd0, 1'b0, 1'b0);
        check("t2_sig", {32'd0, sig_out}, 64'h00000000FB3EE249);

        // T3: bits 0 and 64 cancel in the fold.
        do_run(1, 1'b1, (87'd1 << 64) | 87'd1, 1'b0, 1'b0);
        check("t3_sig", {32'd0, sig_out}, 64'h00000000FB3EE249);

        // T4: zero-length run.
        do_run(0, 1'b0, 87'd0, 1'b0, 1'b0);
        check("t4_sig", {32'd0, sig_out}, {32'd0, SEED});
        check("t4_cnt", {48'd0, sample_cnt}, 64'd0);

        // T1: reset in the middle of a run.
        num_samples = 16'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            y_in = rand_y();
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("t1_busy", {63'd0, busy}, 64'd0);
        check("t1_sig", {32'd0, sig_out}, {32'd0, SEED});
        check("t1_cnt", {48'd0, sample_cnt}, 64'd0);
        check("t1_valid", {63'd0, sig_valid}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t1_stays_idle", {63'd0, busy}, 64'd0);

        // T5: back-pressure in DONE, start ignored there.
        s = SEED;
        for (int i = 0; i < 4; i++) begin
            ys5[i] = rand_y();
            s = model_step(s, ys5[i]);
        end
        exp_q.push_back({s, 16'd4});
        num_samples = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            y_in = ys5[i];
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            check("t5_valid_hold", {63'd0, sig_valid}, 64'd1);
            check("t5_sig_hold", {32'd0, sig_out}, {32'd0, s});
            check("t5_cnt_hold", {48'd0, sample_cnt}, 64'd4);
            y_in = rand_y();
            start = (i == 5);
            num_samples = 16'd7;
            tick();
        end
        start = 1'b1;
        sig_ready = 1'b1;
        tick();
        start = 1'b0;
        sig_ready = 1'b0;
        check("t5_idle_busy", {63'd0, busy}, 64'd0);
        check("t5_idle_valid", {63'd0, sig_valid}, 64'd0);
        tick();
        check("t5_start_ignored", {63'd0, busy}, 64'd0);
        check("t5_sig_kept", {32'd0, sig_out}, {32'd0, s});

        // T6: long random run with num_samples toggled mid-run.
        do_run(1000, 1'b0, 87'd0, 1'b1, 1'b0);

        // Short random runs, some with sig_ready held high throughout.
        for (int k = 0; k < 6; k++) begin
            do_run($urandom_range(1, 40), 1'b0, 87'd0, 1'b0, k[0]);
        end

        tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
